// File: rtl/microsequencer_if.sv
// Sequencing bus between the control register and the microsequencer.
// master drives control fields and conditions; slave returns addresses.
interface microsequencer_if #(
  parameter int unsigned STATE_W = 10,
  parameter int unsigned CR_W    = 6
);
  logic [2:0]         N;
  logic               inv;
  logic [1:0]         select;
  logic [CR_W-1:0]    cr;
  logic [STATE_W-1:0] decoded_state;
  logic [3:0]         cond_in;
  logic [STATE_W-1:0] next_state;
  logic [STATE_W-1:0] state;
  logic               status;

  modport master (
    output N,
    output inv,
    output select,
    output cr,
    output decoded_state,
    output cond_in,
    input  next_state,
    input  state,
    input  status
  );

  modport slave (
    input  N,
    input  inv,
    input  select,
    input  cr,
    input  decoded_state,
    input  cond_in,
    output next_state,
    output state,
    output status
  );
endinterface

// File: rtl/microsequencer.sv
// Next-address generator feeding the microstore address (next_state).
// Ports: clk, reset (sync, active low), bus (slave side of microsequencer_if).
module microsequencer #(
  parameter int unsigned STATE_W     = 10,
  parameter int unsigned CR_W        = 6,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned FETCH_STATE = 1
) (
  input logic              clk,
  input logic              reset,
  microsequencer_if.slave  bus
);

  localparam logic [STATE_W-1:0] RST_A = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] FCH_A = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] ONE   = STATE_W'(1);

  typedef enum logic [2:0] {
    N_ENC  = 3'd0,
    N_FCH  = 3'd1,
    N_JMP  = 3'd2,
    N_INC  = 3'd3,
    N_CBR  = 3'd4,
    N_WAIT = 3'd5,
    N_CALL = 3'd6,
    N_RET  = 3'd7
  } mode_e;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] incr_q;
  logic [STATE_W-1:0] ret_q;
  logic [STATE_W-1:0] target;
  logic [STATE_W-1:0] nxt;
  logic               sts;
  mode_e              mode;

  assign target = STATE_W'(bus.cr);
  assign sts    = bus.cond_in[bus.select] ^ bus.inv;
  assign mode   = mode_e'(bus.N);

  // Reset overrides the mode so the microstore reads RESET_STATE
  // for the whole time reset is held.
  always_comb begin
    nxt = RST_A;
    if (reset) begin
      unique case (mode)
        N_ENC:  nxt = bus.decoded_state;
        N_FCH:  nxt = FCH_A;
        N_JMP:  nxt = target;
        N_INC:  nxt = incr_q;
        N_CBR:  nxt = sts ? target : incr_q;
        N_WAIT: nxt = sts ? incr_q : state_q;
        N_CALL: nxt = target;
        N_RET:  nxt = ret_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_A;
      incr_q  <= RST_A + ONE;
      ret_q   <= '0;
    end else begin
      state_q <= nxt;
      incr_q  <= nxt + ONE;
      // Single-level return: a nested call overwrites it.
      if (mode == N_CALL) ret_q <= incr_q;
    end
  end

  assign bus.next_state = nxt;
  assign bus.state      = state_q;
  assign bus.status     = sts;

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state address generator for the microprogrammed control unit.
- Sits directly upstream of the microstore. Each cycle it consumes the sequencing fields (N, inv, select, cr) latched in the control register and produces next_state, the microstore address.
- The microstore word at next_state is loaded into the control register on the same clock edge that updates this block's internal registers.

Parameters:
STATE_W, 10, width of microstore address / next_state
CR_W, 6, width of cr target field; zero-extended to STATE_W
RESET_STATE, 0, address forced while reset is asserted
FETCH_STATE, 1, address of first fetch microinstruction

Ports:
clk  input  1  system clock, all registers update on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
N  input  3  next-address mode from control register
inv  input  1  inverts selected condition
select  input  2  selects one of cond_in bits
cr  input  CR_W  branch/call target from control register
decoded_state  input  STATE_W  first microstate of current instruction, from instruction encoder
cond_in  input  4  condition sources: [0] moc (memory op complete), [1] condition-tester true, [2] IR link bit, [3] tied 0 by integrator
next_state  output  STATE_W  combinational microstore address
state  output  STATE_W  registered address of microinstruction now in control register
status  output  1  combinational cond_in[select] ^ inv

Behaviour:
- Internal registers: state, incr (holds state+1), ret (single-level return address).
- Reset (reset==0 at rising edge):
  - state <= RESET_STATE, incr <= RESET_STATE+1, ret <= 0.
  - next_state is driven to RESET_STATE combinationally for the whole time reset==0, overriding N.
- Normal edge: state <= next_state; incr <= next_state+1, mod 2^STATE_W (1023 wraps to 0).
- target = {zeros, cr}, zero-extended.
- N decode, combinational, when reset==1:
  - 0 encoder: next_state = decoded_state
  - 1 fetch: FETCH_STATE
  - 2 jump: target
  - 3 increment: incr
  - 4 cond branch: status ? target : incr
  - 5 wait: status ? incr : state (hold until condition, e.g. moc)
  - 6 call: next_state = target; ret <= incr at the edge
  - 7 return: next_state = ret
- ret changes only on reset and on N==6. Nested call overwrites ret, which holds a single level only. Return with no prior call yields 0.
- A call and reset at the same edge: reset wins, ret = 0.
- Reset asserted mid-wait (N==5 holding): at that edge state = RESET_STATE and the wait is abandoned.
- Latency: next_state is valid in the same cycle the control fields settle. Registered state lags next_state by one edge.
- There are no X outputs after the first reset edge. Undriven cond_in is the integrator's responsibility.

Test Plan:
- Reset: hold reset=0 for 2 edges with N=2, cr=6'd20 -> next_state=0, state=0. Release reset with N=1 -> next_state=1; after edge state=1.
- Increment/wrap: force a path to state 1022 via the encoder (decoded_state=10'd1022, N=0), then N=3 -> next_state 1023. Next edge N=3 -> next_state 0.
- Cond branch: state=4, N=4, select=1, cr=20. With cond_in[1]=1, inv=0 -> next_state=20. With cond_in[1]=1, inv=1 -> next_state=5, status=0.
- Wait on moc: state=10, N=5, select=0, moc=0 for 3 edges -> next_state=10 each cycle, state stays 10. Then moc=1 -> next_state=11.
- Call/return: at state 7, N=6, cr=40 -> next_state=40, ret=8. Later N=7 -> next_state=8. Second call from state 50 before return -> return yields 51.
- Reset mid-call: N=6 with reset=0 at the same edge -> state=0, ret=0. Following N=7 -> next_state=0.
